data_mem_ctrl: RTL and testbench

- Processor-side data memory that consumes the request bundle from the data memory unit: req, addr, byte_en, wr and wr_data.
- Returns read data right-justified (byte in [7:0], half in [15:0]), so the upstream unit can apply sign or zero extension unchanged.
- Has a word-wide storage array, a configurable access latency and a stall handshake back to the core.

---
 rtl/data_mem_ctrl_pkg.sv | 24 ++
 rtl/data_mem_ctrl_if.sv | 39 +++
 rtl/data_mem_ctrl_lane_align.sv | 52 +++++
 rtl/data_mem_ctrl.sv | 114 +++++++++++
 tb/tb_data_mem_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data memory controller.
// Access-size codes match the encoding used by the data memory unit.
package data_mem_ctrl_pkg;

    localparam int DMEM_DEPTH_DEFAULT = 1024;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wr_data;
    } mem_req_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory request/response bundle.
// master = core side, slave = memory controller side.
interface data_mem_ctrl_if;

    logic        data_mem_req_i;
    logic [31:0] data_mem_addr_i;
    logic [1:0]  data_mem_byte_en_i;
    logic        data_mem_wr_i;
    logic [31:0] data_mem_wr_data_i;
    logic        mem_stall_o;
    logic [31:0] mem_rd_data_o;
    logic        mem_rd_valid_o;
    logic        mem_misalign_o;

    modport master (
        output data_mem_req_i,
        output data_mem_addr_i,
        output data_mem_byte_en_i,
        output data_mem_wr_i,
        output data_mem_wr_data_i,
        input  mem_stall_o,
        input  mem_rd_data_o,
        input  mem_rd_valid_o,
        input  mem_misalign_o
    );

    modport slave (
        input  data_mem_req_i,
        input  data_mem_addr_i,
        input  data_mem_byte_en_i,
        input  data_mem_wr_i,
        input  data_mem_wr_data_i,
        output mem_stall_o,
        output mem_rd_data_o,
        output mem_rd_valid_o,
        output mem_misalign_o
    );

endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Byte-lane alignment for stores and loads (combinational).
// Misalign flag is live only when DMEM_MISALIGN_CHECK_EN is defined.
module data_mem_ctrl_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [4:0]  shift,
    output logic [31:0] mask,
    output logic        misalign
);

    logic [1:0] eff;

    // Force-align the lane per size and derive enables, shift and mask
    always_comb begin
        eff  = lane;
        be   = 4'b0000;
        mask = 32'h0;
        unique case (size)
            BYTE: begin
                eff  = lane;
                be   = 4'b0001 << eff;
                mask = 32'h0000_00ff;
            end
            HALF_WORD: begin
                eff  = {lane[1], 1'b0};
                be   = 4'b0011 << eff;
                mask = 32'h0000_ffff;
            end
            default: begin
                eff  = 2'b00;
                be   = 4'b1111;
                mask = 32'hffff_ffff;
            end
        endcase
        shift = {eff, 3'b000};
        wdata = wr_data << shift;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (size == HALF_WORD) ? lane[0]
                    : (size == BYTE)      ? 1'b0
                    : (lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-wide data memory with fixed access latency and core stall.
// Optional: DMEM_MISALIGN_CHECK_EN rejects misaligned accesses.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    dmem_state_t       state;
    mem_req_t          req_q;
    logic [3:0]        cnt;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              misalign_q;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [4:0]        shift;
    logic [31:0]       mask;
    logic              misalign;
    logic [31:0]       rword;
    logic [31:0]       ld_data;
    logic              last;
    logic              commit;

    data_mem_ctrl_lane_align u_dmem_lane_align (
        .size     (req_q.size),
        .lane     (req_q.addr[1:0]),
        .wr_data  (req_q.wr_data),
        .be       (be),
        .wdata    (wdata),
        .shift    (shift),
        .mask     (mask),
        .misalign (misalign)
    );

    assign idx     = ADDR_W'(req_q.addr >> 2);
    assign rword   = mem[idx];
    assign ld_data = misalign ? 32'h0 : ((rword >> shift) & mask);
    assign last    = (state == BUSY) && (cnt == 4'd1);
    assign commit  = last && req_q.wr && !misalign;

    assign bus.mem_stall_o    = (state == BUSY) ||
                                ((state == IDLE) && bus.data_mem_req_i);
    assign bus.mem_rd_data_o  = rd_data;
    assign bus.mem_rd_valid_o = rd_valid;
    assign bus.mem_misalign_o = misalign_q;

    // Request capture, latency countdown and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= 4'd0;
            rd_data    <= 32'h0;
            rd_valid   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.data_mem_req_i) begin
                        req_q.addr    <= bus.data_mem_addr_i;
                        req_q.size    <= bus.data_mem_byte_en_i;
                        req_q.wr      <= bus.data_mem_wr_i;
                        req_q.wr_data <= bus.data_mem_wr_data_i;
                        cnt           <= 4'(LATENCY);
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        misalign_q <= misalign;
                        if (!req_q.wr) begin
                            rd_valid <= 1'b1;
                            rd_data  <= ld_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane store commit; reset on the commit edge drops the store
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (LATENCY=1 and LATENCY=4 instances).
// Expectations follow DMEM_MISALIGN_CHECK_EN when it is defined.
module tb_data_mem_ctrl;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    data_mem_ctrl_if bus1 ();
    data_mem_ctrl_if bus4 ();

    data_mem_ctrl #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    data_mem_ctrl #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on the LATENCY=1 instance; returns stall cycle count
    // and the response flags/data seen in the first non-stall cycle.
    task automatic acc(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output int n, output logic v, output logic m,
                       output logic [31:0] rd);
        @(negedge clk);
        bus1.data_mem_req_i     = 1'b1;
        bus1.data_mem_wr_i      = w;
        bus1.data_mem_byte_en_i = sz;
        bus1.data_mem_addr_i    = a;
        bus1.data_mem_wr_data_i = d;
        #1;
        n = 0;
        while (bus1.mem_stall_o && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        v  = bus1.mem_rd_valid_o;
        m  = bus1.mem_misalign_o;
        rd = bus1.mem_rd_data_o;
        bus1.data_mem_req_i = 1'b0;
    endtask

    int          n;
    logic        v;
    logic        m;
    logic [31:0] rd;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.data_mem_req_i     = 1'b0;
        bus1.data_mem_wr_i      = 1'b0;
        bus1.data_mem_byte_en_i = SZ_W;
        bus1.data_mem_addr_i    = 32'h0;
        bus1.data_mem_wr_data_i = 32'h0;
        bus4.data_mem_req_i     = 1'b0;
        bus4.data_mem_wr_i      = 1'b0;
        bus4.data_mem_byte_en_i = SZ_W;
        bus4.data_mem_addr_i    = 32'h0;
        bus4.data_mem_wr_data_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        check("rst_stall", 32'(bus1.mem_stall_o), 32'h0);
        check("rst_valid", 32'(bus1.mem_rd_valid_o), 32'h0);
        check("rst_data", bus1.mem_rd_data_o, 32'h0);
        check("rst_misal", 32'(bus1.mem_misalign_o), 32'h0);
        check("rst_stall4", 32'(bus4.mem_stall_o), 32'h0);

        acc(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, n, v, m, rd);
        check("st_cycles", 32'(n), 32'd2);
        check("st_valid", 32'(v), 32'h0);
        acc(1'b0, SZ_W, 32'h10, 32'h0, n, v, m, rd);
        check("ld_cycles", 32'(n), 32'd2);
        check("ld_valid", 32'(v), 32'h1);
        check("ld_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("valid_pulse", 32'(bus1.mem_rd_valid_o), 32'h0);
        check("data_hold", bus1.mem_rd_data_o, 32'hDEADBEEF);

        acc(1'b1, SZ_W, 32'h20, 32'h11223344, n, v, m, rd);
        acc(1'b1, SZ_B, 32'h23, 32'h000000AA, n, v, m, rd);
        acc(1'b0, SZ_W, 32'h20, 32'h0, n, v, m, rd);
        check("byte_st_word", rd, 32'hAA223344);
        acc(1'b0, SZ_B, 32'h23, 32'h0, n, v, m, rd);
        check("byte_ld", rd, 32'h000000AA);
        acc(1'b0, SZ_H, 32'h22, 32'h0, n, v, m, rd);
        check("half_ld", rd, 32'h0000AA22);
        acc(1'b0, SZ_B, 32'h21, 32'h0, n, v, m, rd);
        check("byte_ld_l1", rd, 32'h00000033);
        acc(1'b0, 2'b10, 32'h20, 32'h0, n, v, m, rd);
        check("size10_word", rd, 32'hAA223344);

        acc(1'b1, SZ_W, 32'h1000, 32'h5, n, v, m, rd);
        acc(1'b0, SZ_W, 32'h0, 32'h0, n, v, m, rd);
        check("wrap", rd, 32'h00000005);

        // LATENCY=4: store, then a load presented in RESP
        @(negedge clk);
        bus4.data_mem_req_i     = 1'b1;
        bus4.data_mem_wr_i      = 1'b1;
        bus4.data_mem_byte_en_i = SZ_W;
        bus4.data_mem_addr_i    = 32'h8;
        bus4.data_mem_wr_data_i = 32'hCAFEF00D;
        #1;
        n = 0;
        while (bus4.mem_stall_o && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("l4_st_cycles", 32'(n), 32'd5);
        check("l4_st_valid", 32'(bus4.mem_rd_valid_o), 32'h0);
        bus4.data_mem_wr_i = 1'b0;
        #1;
        check("l4_resp_ign", 32'(bus4.mem_stall_o), 32'h0);
        @(negedge clk);
        #1;
        n = 0;
        while (bus4.mem_stall_o && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("l4_ld_cycles", 32'(n), 32'd5);
        check("l4_ld_valid", 32'(bus4.mem_rd_valid_o), 32'h1);
        check("l4_ld_data", bus4.mem_rd_data_o, 32'hCAFEF00D);
        bus4.data_mem_req_i = 1'b0;

        // Reset while a store is in BUSY
        acc(1'b1, SZ_W, 32'h40, 32'h00009999, n, v, m, rd);
        @(negedge clk);
        bus1.data_mem_req_i     = 1'b1;
        bus1.data_mem_wr_i      = 1'b1;
        bus1.data_mem_byte_en_i = SZ_W;
        bus1.data_mem_addr_i    = 32'h40;
        bus1.data_mem_wr_data_i = 32'h00001234;
        @(negedge clk);
        reset = 1'b1;
        bus1.data_mem_req_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy_stall", 32'(bus1.mem_stall_o), 32'h0);
        check("rst_busy_valid", 32'(bus1.mem_rd_valid_o), 32'h0);
        check("rst_busy_data", bus1.mem_rd_data_o, 32'h0);
        reset = 1'b0;
        acc(1'b0, SZ_W, 32'h40, 32'h0, n, v, m, rd);
        check("rst_no_commit", rd, 32'h00009999);

        // Misaligned half-word store and load
        acc(1'b1, SZ_W, 32'h40, 32'hAABBCCDD, n, v, m, rd);
        acc(1'b1, SZ_H, 32'h41, 32'h00005566, n, v, m, rd);
        check("mis_st_cycles", 32'(n), 32'd2);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_st_flag", 32'(m), 32'h1);
`else
        check("mis_st_flag", 32'(m), 32'h0);
`endif
        acc(1'b0, SZ_W, 32'h40, 32'h0, n, v, m, rd);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_st_mem", rd, 32'hAABBCCDD);
`else
        check("mis_st_mem", rd, 32'hAABB5566);
`endif
        acc(1'b0, SZ_H, 32'h41, 32'h0, n, v, m, rd);
        check("mis_ld_valid", 32'(v), 32'h1);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_ld_flag", 32'(m), 32'h1);
        check("mis_ld_data", rd, 32'h0);
`else
        check("mis_ld_flag", 32'(m), 32'h0);
        check("mis_ld_data", rd, 32'h00005566);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
